// File: rtl/lcd_bus_arb.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_arb
// Brief   : Round-robin packet arbiter and WR-strobe sequencer for a shared
//           8-bit 8080-style LCD write bus.
// Rev     : 1.0
// ============================================================================
module lcd_bus_arb #(
    parameter int N_REQ   = 3,
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1,
    parameter int GAP_MAX = 255
) (
    input  logic                 i_clk,
    input  logic                 i_res,
    input  logic [N_REQ-1:0]     i_valid,
    input  logic [8*N_REQ-1:0]   i_data,
    input  logic [N_REQ-1:0]     i_dc,
    input  logic [N_REQ-1:0]     i_last,
    output logic [N_REQ-1:0]     o_ready,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_lcd_data,
    output logic                 o_lcd_wr,
    output logic                 o_lcd_dc,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int c_IDX_W  = $clog2(N_REQ);
    localparam int c_PH_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
    localparam int c_GAP_W  = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_LOW  = 2'd2,
        S_HIGH = 2'd3
    } state_t;

    state_t               r_state;
    logic [N_REQ-1:0]     r_grant;
    logic [c_IDX_W-1:0]   r_gidx;
    logic [c_IDX_W-1:0]   r_ptr;
    logic                 r_last;
    logic [c_PH_W-1:0]    r_ph;
    logic [c_GAP_W-1:0]   r_gap;
    logic [7:0]           r_lcd_data;
    logic                 r_lcd_wr;
    logic                 r_lcd_dc;
    logic                 r_busy;
    logic                 r_err;

    logic                 w_sel_valid;
    logic [7:0]           w_sel_data;
    logic                 w_sel_dc;
    logic                 w_sel_last;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;
    logic [c_IDX_W:0]     w_sum;
    logic [N_REQ-1:0]     w_pick_oh;
    logic [c_IDX_W-1:0]   w_ptr_next;

    // Mux the granted requester's byte lane
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = 8'h00;
        w_sel_dc    = 1'b0;
        w_sel_last  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gidx == c_IDX_W'(k)) begin
                w_sel_valid = i_valid[k];
                w_sel_data  = i_data[8*k +: 8];
                w_sel_dc    = i_dc[k];
                w_sel_last  = i_last[k];
            end
        end
    end

    // First valid requester at or above the pointer, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (c_IDX_W+1)'(i);
            if (w_sum >= (c_IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (c_IDX_W+1)'(N_REQ);
            end
            if (!w_found && i_valid[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_ptr_next = (r_gidx == c_IDX_W'(N_REQ-1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_last     <= 1'b0;
            r_ph       <= '0;
            r_gap      <= '0;
            r_lcd_data <= 8'h00;
            r_lcd_wr   <= 1'b1;
            r_lcd_dc   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick;
                        r_gap   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_sel_valid) begin
                        r_lcd_data <= w_sel_data;
                        r_lcd_dc   <= w_sel_dc;
                        r_last     <= w_sel_last;
                        r_gap      <= '0;
                        r_ph       <= '0;
                        r_lcd_wr   <= 1'b0;
                        r_state    <= S_LOW;
                    end else if (r_gap == c_GAP_W'(GAP_MAX-1)) begin
                        // Owner stalled too long mid-packet: revoke and move on
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_ph == c_PH_W'(WR_LOW-1)) begin
                        r_ph     <= '0;
                        r_lcd_wr <= 1'b1;
                        r_state  <= S_HIGH;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_ph == c_PH_W'(WR_HIGH-1)) begin
                        r_ph <= '0;
                        if (r_last) begin
                            r_ptr   <= w_ptr_next;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == S_LOAD) ? (r_grant & i_valid) : '0;
    assign o_grant    = r_grant;
    assign o_lcd_data = r_lcd_data;
    assign o_lcd_wr   = r_lcd_wr;
    assign o_lcd_dc   = r_lcd_dc;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_bus_arb
// Brief   : Directed self-checking bench for lcd_bus_arb (two parameter sets).
// Rev     : 1.0
// ============================================================================
module tb_lcd_bus_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default strobe widths, short gap timeout
    logic [2:0]  a_valid, a_dc, a_last, a_ready, a_grant;
    logic [23:0] a_data;
    logic [7:0]  a_lcd_data;
    logic        a_wr, a_dc_o, a_busy, a_err;

    lcd_bus_arb #(.N_REQ(3), .WR_LOW(1), .WR_HIGH(1), .GAP_MAX(4)) u_a (
        .i_clk(clk), .i_res(rst), .i_valid(a_valid), .i_data(a_data),
        .i_dc(a_dc), .i_last(a_last), .o_ready(a_ready), .o_grant(a_grant),
        .o_lcd_data(a_lcd_data), .o_lcd_wr(a_wr), .o_lcd_dc(a_dc_o),
        .o_busy(a_busy), .o_err(a_err)
    );

    // Instance B: stretched strobe
    logic [2:0]  b_valid = 3'b000, b_dc = 3'b000, b_last = 3'b000;
    logic [2:0]  b_ready, b_grant;
    logic [23:0] b_data = 24'h0;
    logic [7:0]  b_lcd_data;
    logic        b_wr, b_dc_o, b_busy, b_err;

    lcd_bus_arb #(.N_REQ(3), .WR_LOW(3), .WR_HIGH(2), .GAP_MAX(255)) u_b (
        .i_clk(clk), .i_res(rst), .i_valid(b_valid), .i_data(b_data),
        .i_dc(b_dc), .i_last(b_last), .o_ready(b_ready), .o_grant(b_grant),
        .o_lcd_data(b_lcd_data), .o_lcd_wr(b_wr), .o_lcd_dc(b_dc_o),
        .o_busy(b_busy), .o_err(b_err)
    );

    // Per-requester byte FIFOs feeding instance A: {last, dc, data}
    logic [9:0] a_mem [3][16];
    logic [3:0] a_head [3];
    logic [3:0] a_tail [3];

    for (genvar k = 0; k < 3; k++) begin : g_src
        assign a_valid[k]       = (a_head[k] != a_tail[k]);
        assign a_data[8*k +: 8] = a_mem[k][a_head[k]][7:0];
        assign a_dc[k]          = a_mem[k][a_head[k]][8];
        assign a_last[k]        = a_mem[k][a_head[k]][9];
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (a_ready[k]) a_head[k] <= a_head[k] + 4'd1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Strobe log for instance A, one entry per WR falling edge
    logic [7:0] log_data  [32];
    logic       log_dc    [32];
    logic [2:0] log_grant [32];
    int         log_t     [32];
    int         log_low   [32];
    int         n_log = 0;
    int         err_cnt = 0, err_cyc = 0, rdy2_bad = 0, lowcnt = 0;
    logic [2:0] err_grant = 3'b000;
    logic       prev_wr = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 1'b1;
            lowcnt  = 0;
        end else begin
            if (!a_wr) begin
                if (prev_wr && n_log < 32) begin
                    log_t[n_log]     = cyc;
                    log_data[n_log]  = a_lcd_data;
                    log_dc[n_log]    = a_dc_o;
                    log_grant[n_log] = a_grant;
                    n_log++;
                    lowcnt = 0;
                end
                lowcnt++;
            end else if (!prev_wr && n_log > 0) begin
                log_low[n_log-1] = lowcnt;
                check("hold_data", {24'h0, a_lcd_data}, {24'h0, log_data[n_log-1]});
                check("hold_dc", {31'h0, a_dc_o}, {31'h0, log_dc[n_log-1]});
            end
            if (a_err) begin
                err_cnt++;
                err_cyc   = cyc;
                err_grant = a_grant;
            end
            if (a_ready[2] && a_grant != 3'b100) rdy2_bad++;
            prev_wr = a_wr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_head[k] = 4'd0;
            a_tail[k] = 4'd0;
        end
        n_log = 0; err_cnt = 0; rdy2_bad = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic dc, input logic last);
        a_mem[k][a_tail[k]] = {last, dc, d};
        a_tail[k] = a_tail[k] + 4'd1;
    endtask

    task automatic wait_log(input int cnt, input int bound, input string tag);
        for (int i = 0; i < bound && n_log < cnt; i++) begin
            @(negedge clk); #1;
        end
        check(tag, {31'h0, n_log >= cnt}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  e2d [7];
        logic [2:0]  e2g [7];
        logic [10:0] wvec, bvec;
        logic [7:0]  dvec;
        logic        found;

        // Reset state
        start_reset();
        check("rst_wr", {31'h0, a_wr}, 32'd1);
        check("rst_data", {24'h0, a_lcd_data}, 32'h0);
        check("rst_dc", {31'h0, a_dc_o}, 32'd0);
        check("rst_grant", {29'h0, a_grant}, 32'd0);
        check("rst_ready", {29'h0, a_ready}, 32'd0);
        check("rst_busy", {31'h0, a_busy}, 32'd0);
        check("rst_err", {31'h0, a_err}, 32'd0);
        check("rst_b_wr", {31'h0, b_wr}, 32'd1);

        // Single requester, three-byte packet
        push(0, 8'h2A, 1'b0, 1'b0);
        push(0, 8'h00, 1'b1, 1'b0);
        push(0, 8'hEF, 1'b1, 1'b1);
        rst = 1'b0;
        wait_log(3, 30, "t1_wait");
        tick(6);
        check("t1_d0", {24'h0, log_data[0]}, 32'h2A);
        check("t1_d1", {24'h0, log_data[1]}, 32'h00);
        check("t1_d2", {24'h0, log_data[2]}, 32'hEF);
        check("t1_dc0", {31'h0, log_dc[0]}, 32'd0);
        check("t1_dc2", {31'h0, log_dc[2]}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t1_grant", {29'h0, log_grant[i]}, 32'd1);
            check("t1_low", log_low[i], 32'd1);
        end
        check("t1_sp01", log_t[1] - log_t[0], 32'd3);
        check("t1_sp12", log_t[2] - log_t[1], 32'd3);
        check("t1_grant_end", {29'h0, a_grant}, 32'd0);
        check("t1_busy_end", {31'h0, a_busy}, 32'd0);

        // Three requesters contending, requester 0 re-requests mid-stream
        start_reset();
        push(0, 8'hA0, 1'b1, 1'b0); push(0, 8'hA1, 1'b1, 1'b1);
        push(1, 8'hB0, 1'b1, 1'b0); push(1, 8'hB1, 1'b1, 1'b1);
        push(2, 8'hC0, 1'b1, 1'b0); push(2, 8'hC1, 1'b1, 1'b1);
        rst = 1'b0;
        wait_log(3, 40, "t2_wait_a");
        push(0, 8'hD0, 1'b1, 1'b1);
        wait_log(7, 60, "t2_wait_b");
        tick(6);
        e2d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0};
        e2g = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        for (int i = 0; i < 7; i++) begin
            check("t2_data", {24'h0, log_data[i]}, {24'h0, e2d[i]});
            check("t2_grant", {29'h0, log_grant[i]}, {29'h0, e2g[i]});
        end
        check("t2_sp_intra", log_t[1] - log_t[0], 32'd3);
        check("t2_sp_inter", log_t[2] - log_t[1], 32'd4);

        // Non-owner must not see ready while another packet is in flight
        start_reset();
        push(1, 8'h31, 1'b1, 1'b0); push(1, 8'h32, 1'b1, 1'b0); push(1, 8'h33, 1'b1, 1'b1);
        rst = 1'b0;
        wait_log(1, 20, "t3_wait_a");
        push(2, 8'h44, 1'b0, 1'b1);
        wait_log(4, 40, "t3_wait_b");
        tick(4);
        check("t3_rdy2_bad", rdy2_bad, 32'd0);
        check("t3_g2", {29'h0, log_grant[2]}, 32'b010);
        check("t3_g3", {29'h0, log_grant[3]}, 32'b100);
        check("t3_d3", {24'h0, log_data[3]}, 32'h44);

        // Gap timeout revokes the grant and advances the pointer
        start_reset();
        push(0, 8'h55, 1'b1, 1'b0);
        push(1, 8'h66, 1'b0, 1'b1);
        rst = 1'b0;
        wait_log(2, 60, "t5_wait");
        tick(4);
        check("t5_err_cnt", err_cnt, 32'd1);
        check("t5_err_time", err_cyc - log_t[0], 32'd6);
        check("t5_err_grant", {29'h0, err_grant}, 32'd0);
        check("t5_next_time", log_t[1] - log_t[0], 32'd8);
        check("t5_g0", {29'h0, log_grant[0]}, 32'b001);
        check("t5_g1", {29'h0, log_grant[1]}, 32'b010);
        check("t5_d1", {24'h0, log_data[1]}, 32'h66);
        check("t5_err_now", {31'h0, a_err}, 32'd0);

        // Reset during LOW of the second byte
        start_reset();
        push(0, 8'h01, 1'b0, 1'b0); push(0, 8'h02, 1'b1, 1'b0); push(0, 8'h03, 1'b1, 1'b1);
        rst = 1'b0;
        wait_log(2, 30, "t6_wait_a");
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_wr", {31'h0, a_wr}, 32'd1);
        check("t6_data", {24'h0, a_lcd_data}, 32'h0);
        check("t6_grant", {29'h0, a_grant}, 32'd0);
        check("t6_busy", {31'h0, a_busy}, 32'd0);
        start_reset();
        push(1, 8'h77, 1'b0, 1'b1);
        push(0, 8'h88, 1'b0, 1'b1);
        rst = 1'b0;
        wait_log(2, 30, "t6_wait_b");
        check("t6_g0", {29'h0, log_grant[0]}, 32'b001);
        check("t6_d0", {24'h0, log_data[0]}, 32'h88);
        check("t6_g1", {29'h0, log_grant[1]}, 32'b010);

        // Stretched strobe on instance B: WR_LOW=3, WR_HIGH=2
        tick(2);
        b_data = 24'h000011; b_last = 3'b000; b_valid = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            found = b_ready[0];
        end
        check("b_first_ready", {31'h0, found}, 32'd1);
        @(posedge clk); #1;
        b_data = 24'h000022; b_last = 3'b001;
        wvec = '0; bvec = '0; dvec = '0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); #1;
            wvec[i] = b_wr;
            bvec[i] = b_busy;
            if (i == 7) dvec = b_lcd_data;
            if (i == 5) begin
                check("b_ready_6", {31'h0, b_ready[0]}, 32'd1);
                @(posedge clk); #1;
                b_valid = 3'b000;
            end
        end
        @(negedge clk); #1;
        check("b_wr_pattern", {21'h0, wvec}, {21'h0, 11'b11000111000});
        check("b_busy_held", {21'h0, bvec}, {21'h0, 11'h7FF});
        check("b_data2", {24'h0, dvec}, 32'h22);
        check("b_busy_end", {31'h0, b_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
